// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use interlock, EX multi-cycle stall
// with watchdog release, flush sequencing and a saturating stall-cycle counter.
module hazard_ctrl #(
  parameter int MAX_EX_STALL = 32,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_is_load_i,
  input  logic             ex_wreg_i,
  input  logic [4:0]       ex_wd_i,
  input  logic             id_reg1_read_i,
  input  logic [4:0]       id_reg1_addr_i,
  input  logic             id_reg2_read_i,
  input  logic [4:0]       id_reg2_addr_i,
  input  logic             ex_busy_i,
  input  logic             flush_req_i,
  output logic [5:0]       stall_o,
  output logic             flush_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam int BUSY_W = $clog2(MAX_EX_STALL + 1);

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_LU   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXBUSY = 2'd1,
    DRAIN  = 2'd2,
    FLUSH  = 2'd3
  } state_t;

  state_t            state;
  logic [BUSY_W-1:0] busy_cnt;
  logic              lu_hazard;
  logic              wd_nonzero;
  logic              src1_match;
  logic              src2_match;
  logic              watchdog_hit;

  // A load result is only available after MEM, so an ID read of its
  // destination cannot be forwarded from EX; $0 is never a real dependency.
  assign wd_nonzero   = (ex_wd_i != 5'd0);
  assign src1_match   = id_reg1_read_i && (id_reg1_addr_i == ex_wd_i);
  assign src2_match   = id_reg2_read_i && (id_reg2_addr_i == ex_wd_i);
  assign lu_hazard    = ex_is_load_i && ex_wreg_i && wd_nonzero && (src1_match || src2_match);
  assign watchdog_hit = (busy_cnt == BUSY_W'(MAX_EX_STALL));

  always_comb begin
    stall_o = STALL_NONE;
    if (!rst) begin
      unique case (state)
        IDLE: begin
          if (flush_req_i)
            stall_o = STALL_NONE;
          else if (ex_busy_i)
            stall_o = STALL_EX;
          else if (lu_hazard)
            stall_o = STALL_LU;
        end
        EXBUSY: begin
          if (flush_req_i)
            stall_o = STALL_NONE;
          else if (!ex_busy_i)
            stall_o = lu_hazard ? STALL_LU : STALL_NONE;
          else if (!watchdog_hit)
            stall_o = STALL_EX;
        end
        DRAIN:   stall_o = STALL_NONE;
        FLUSH:   stall_o = STALL_NONE;
        default: stall_o = STALL_NONE;
      endcase
    end
  end

  // flush_o is high exactly for the cycles the FSM sits in FLUSH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy_cnt  <= '0;
      flush_o   <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      flush_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (flush_req_i) begin
            state   <= FLUSH;
            flush_o <= 1'b1;
          end else if (ex_busy_i) begin
            state    <= EXBUSY;
            busy_cnt <= BUSY_W'(1);
          end
        end
        EXBUSY: begin
          if (flush_req_i) begin
            state    <= FLUSH;
            flush_o  <= 1'b1;
            busy_cnt <= '0;
          end else if (!ex_busy_i) begin
            state    <= IDLE;
            busy_cnt <= '0;
          end else if (watchdog_hit) begin
            state     <= DRAIN;
            timeout_o <= 1'b1;
            busy_cnt  <= '0;
          end else begin
            busy_cnt <= busy_cnt + BUSY_W'(1);
          end
        end
        DRAIN: begin
          if (flush_req_i) begin
            state   <= FLUSH;
            flush_o <= 1'b1;
          end else if (!ex_busy_i) begin
            state <= IDLE;
          end
        end
        FLUSH: begin
          if (flush_req_i) begin
            flush_o <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          busy_cnt <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt_o <= '0;
    else if ((stall_o != STALL_NONE) && (stall_cnt_o != {CNT_W{1'b1}}))
      stall_cnt_o <= stall_cnt_o + CNT_W'(1);
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized bench for hazard_ctrl: a rule-level model predicts every output
// each cycle, and a few directed sequences pin hand-computed values.
module tb_hazard_ctrl;

  localparam int MAX_EX_STALL = 32;
  localparam int CNT_W        = 8;
  localparam int CNT_MAX      = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic             ex_is_load_i;
  logic             ex_wreg_i;
  logic [4:0]       ex_wd_i;
  logic             id_reg1_read_i;
  logic [4:0]       id_reg1_addr_i;
  logic             id_reg2_read_i;
  logic [4:0]       id_reg2_addr_i;
  logic             ex_busy_i;
  logic             flush_req_i;
  logic [5:0]       stall_o;
  logic             flush_o;
  logic             timeout_o;
  logic [CNT_W-1:0] stall_cnt_o;

  int checks = 0;
  int errors = 0;

  hazard_ctrl #(
    .MAX_EX_STALL(MAX_EX_STALL),
    .CNT_W       (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ex_is_load_i  (ex_is_load_i),
    .ex_wreg_i     (ex_wreg_i),
    .ex_wd_i       (ex_wd_i),
    .id_reg1_read_i(id_reg1_read_i),
    .id_reg1_addr_i(id_reg1_addr_i),
    .id_reg2_read_i(id_reg2_read_i),
    .id_reg2_addr_i(id_reg2_addr_i),
    .ex_busy_i     (ex_busy_i),
    .flush_req_i   (flush_req_i),
    .stall_o       (stall_o),
    .flush_o       (flush_o),
    .timeout_o     (timeout_o),
    .stall_cnt_o   (stall_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic load, input logic wreg, input logic [4:0] wd,
                               input logic r1, input logic [4:0] a1,
                               input logic r2, input logic [4:0] a2,
                               input logic busy, input logic flush);
    @(posedge clk);
    #1;
    ex_is_load_i   = load;
    ex_wreg_i      = wreg;
    ex_wd_i        = wd;
    id_reg1_read_i = r1;
    id_reg1_addr_i = a1;
    id_reg2_read_i = r2;
    id_reg2_addr_i = a2;
    ex_busy_i      = busy;
    flush_req_i    = flush;
  endtask

  task automatic applyIdle();
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic pulseReset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Reference model: flush_o is last cycle's accepted flush request, and an EX
  // busy episode is granted at most MAX_EX_STALL stall cycles before draining.
  int   m_granted = 0;
  bit   m_drain   = 0;
  bit   m_flush   = 0;
  bit   m_timeout = 0;
  int   m_cnt     = 0;
  int   n_granted;
  bit   n_drain;
  bit   n_flush;
  bit   n_timeout;
  int   n_cnt;

  always @(negedge clk) begin
    logic [5:0] exp_stall;
    bit         lu;
    lu = ex_is_load_i && ex_wreg_i && (ex_wd_i != 0) &&
         ((id_reg1_read_i && id_reg1_addr_i == ex_wd_i) ||
          (id_reg2_read_i && id_reg2_addr_i == ex_wd_i));
    exp_stall = 6'b000000;
    n_granted = 0;
    n_drain   = 0;
    n_flush   = 0;
    n_timeout = m_timeout;
    if (rst) begin
      n_timeout = 0;
      n_cnt     = 0;
      checkOutput("rst_stall",   32'(stall_o),     32'd0);
      checkOutput("rst_flush",   32'(flush_o),     32'd0);
      checkOutput("rst_timeout", 32'(timeout_o),   32'd0);
      checkOutput("rst_cnt",     32'(stall_cnt_o), 32'd0);
    end else begin
      if (flush_req_i) begin
        n_flush = 1;
      end else if (m_flush) begin
        exp_stall = 6'b000000;
      end else if (m_drain) begin
        n_drain = ex_busy_i;
      end else if (ex_busy_i) begin
        if (m_granted < MAX_EX_STALL) begin
          exp_stall = 6'b001111;
          n_granted = m_granted + 1;
        end else begin
          n_drain   = 1;
          n_timeout = 1;
        end
      end else if (lu) begin
        exp_stall = 6'b000111;
      end
      n_cnt = (exp_stall != 0 && m_cnt < CNT_MAX) ? m_cnt + 1 : m_cnt;
      checkOutput("model_stall",   32'(stall_o),     32'(exp_stall));
      checkOutput("model_flush",   32'(flush_o),     32'(m_flush));
      checkOutput("model_timeout", 32'(timeout_o),   32'(m_timeout));
      checkOutput("model_cnt",     32'(stall_cnt_o), 32'(m_cnt));
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_granted <= 0;
      m_drain   <= 0;
      m_flush   <= 0;
      m_timeout <= 0;
      m_cnt     <= 0;
    end else begin
      m_granted <= n_granted;
      m_drain   <= n_drain;
      m_flush   <= n_flush;
      m_timeout <= n_timeout;
      m_cnt     <= n_cnt;
    end
  end

  int busy_left;
  logic rnd_flush;

  initial begin
    rst = 1'b0;
    ex_is_load_i = 0; ex_wreg_i = 0; ex_wd_i = 0;
    id_reg1_read_i = 0; id_reg1_addr_i = 0;
    id_reg2_read_i = 0; id_reg2_addr_i = 0;
    ex_busy_i = 0; flush_req_i = 0;
    #2 rst = 1'b1;
    @(negedge clk);
    checkOutput("reset_stall", 32'(stall_o),     32'd0);
    checkOutput("reset_cnt",   32'(stall_cnt_o), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Load-use on source 1 stalls exactly one cycle.
    applyStimulus(1, 1, 5'd1, 1, 5'd1, 0, 5'd0, 0, 0);
    @(negedge clk) checkOutput("lu_stall", 32'(stall_o), 32'h07);
    applyIdle();
    @(negedge clk) checkOutput("lu_release", 32'(stall_o), 32'h00);
    checkOutput("lu_cnt", 32'(stall_cnt_o), 32'd1);

    // $0 destination and non-load producers never stall.
    applyStimulus(1, 1, 5'd0, 1, 5'd0, 1, 5'd0, 0, 0);
    @(negedge clk) checkOutput("r0_no_stall", 32'(stall_o), 32'h00);
    applyStimulus(0, 1, 5'd1, 1, 5'd1, 0, 5'd0, 0, 0);
    @(negedge clk) checkOutput("nonload_no_stall", 32'(stall_o), 32'h00);

    // Short EX busy: five stall cycles, no watchdog.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0);
      @(negedge clk) checkOutput("exbusy_stall", 32'(stall_o), 32'h0F);
    end
    applyIdle();
    @(negedge clk) checkOutput("exbusy_release", 32'(stall_o), 32'h00);
    checkOutput("exbusy_timeout", 32'(timeout_o), 32'd0);
    checkOutput("exbusy_cnt", 32'(stall_cnt_o), 32'd6);

    // Busy held 40 cycles: 32 stall cycles, then drain with timeout set.
    for (int i = 0; i < 40; i++) begin
      applyStimulus(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0);
      @(negedge clk) checkOutput("watchdog_stall", 32'(stall_o), (i < 32) ? 32'h0F : 32'h00);
    end
    checkOutput("watchdog_timeout", 32'(timeout_o), 32'd1);
    applyIdle();
    @(negedge clk) checkOutput("drain_exit_stall", 32'(stall_o), 32'h00);
    checkOutput("timeout_sticky", 32'(timeout_o), 32'd1);
    checkOutput("watchdog_cnt", 32'(stall_cnt_o), 32'd38);

    // Flush during EX busy: stall drops at once, flush_o follows for one cycle.
    applyStimulus(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0);
    applyStimulus(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0);
    applyStimulus(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 1);
    @(negedge clk) checkOutput("flush_req_stall", 32'(stall_o), 32'h00);
    checkOutput("flush_not_yet", 32'(flush_o), 32'd0);
    applyStimulus(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0);
    @(negedge clk) checkOutput("flush_pulse", 32'(flush_o), 32'd1);
    checkOutput("flush_state_stall", 32'(stall_o), 32'h00);
    applyIdle();
    @(negedge clk) checkOutput("flush_done", 32'(flush_o), 32'd0);
    checkOutput("flush_cnt", 32'(stall_cnt_o), 32'd40);

    // Asynchronous reset in the middle of an EX busy stall.
    applyStimulus(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0);
    applyStimulus(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_stall",   32'(stall_o),     32'h00);
    checkOutput("async_rst_timeout", 32'(timeout_o),   32'd0);
    checkOutput("async_rst_cnt",     32'(stall_cnt_o), 32'd0);
    ex_busy_i = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk) checkOutput("post_rst_stall", 32'(stall_o), 32'h00);

    // Random traffic: bursty busy episodes, rare flushes and resets.
    busy_left = 0;
    for (int c = 0; c < 4000; c++) begin
      if (busy_left == 0 && $urandom_range(0, 9) == 0)
        busy_left = $urandom_range(1, 45);
      rnd_flush = ($urandom_range(0, 39) == 0);
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                    busy_left > 0, rnd_flush);
      if (busy_left > 0) busy_left--;
      if ($urandom_range(0, 999) == 0) begin
        pulseReset();
        busy_left = 0;
      end
    end

    applyIdle();
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
